// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared types and helpers for the UART transmit arbiter
package uart_tx_arb_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} tx_seq_state_t;
  function automatic int rr_ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and transmitter handshake bundle
interface uart_tx_arbiter_if #(parameter int NREQ = 2);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [8*NREQ-1:0] req_data;
  logic [7:0] sdata;
  logic tx_start;
  logic tx_busy;
  modport master(output req_valid, req_data, tx_busy, input req_ready, sdata, tx_start);
  modport slave(input req_valid, req_data, tx_busy, output req_ready, sdata, tx_start);
endinterface

// File: rtl/uart_tx_arbiter_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, power-of-two depth
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign rdata = mem_q[rp_q];
  assign count = cnt_q;
  always_comb begin
    wp_d = wp_q + AW'(do_push);
    rp_d = rp_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter through a FIFO.
// Optional per-requester statistics when UART_TX_ARB_STATS_EN is defined.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rstn,
  uart_tx_arbiter_if.slave bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic idle
`ifdef UART_TX_ARB_STATS_EN
  ,
  output logic [32*NREQ-1:0] stat_bytes,
  output logic [31:0] stat_full_cycles
`endif
);
  localparam int PW = rr_ptr_w(NREQ);
  logic [PW-1:0] rr_q, rr_d, gidx, idx;
  logic found, push, pop, full, empty;
  logic [NREQ-1:0][BYTE_W-1:0] req_bytes;
  logic [BYTE_W-1:0] head, sdata_q, sdata_d;
  logic start_q, start_d;
  tx_seq_state_t state_q, state_d;
  assign req_bytes = bus.req_data;
  always_comb begin
    found = 1'b0;
    gidx = rr_q;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(rr_q) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        gidx = idx;
      end
    end
  end
  assign push = found & ~full;
  assign bus.req_ready = {NREQ{push}} & (NREQ'(1) << gidx);
  assign rr_d = push ? ((gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1) : rr_q;
  sync_fifo #(.W(BYTE_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rstn(rstn), .push(push), .pop(pop), .wdata(req_bytes[gidx]),
    .rdata(head), .count(fifo_count), .full(full), .empty(empty)
  );
  // Launch only from S_IDLE with the link quiet; the pop commits the head byte.
  always_comb begin
    state_d = state_q;
    sdata_d = sdata_q;
    start_d = 1'b0;
    pop = 1'b0;
    case (state_q)
      S_IDLE: if (!empty && !bus.tx_busy) begin
        state_d = S_WAIT_BUSY;
        sdata_d = head;
        start_d = 1'b1;
        pop = 1'b1;
      end
      S_WAIT_BUSY: state_d = bus.tx_busy ? S_WAIT_DONE : S_WAIT_BUSY;
      S_WAIT_DONE: state_d = bus.tx_busy ? S_WAIT_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      sdata_q <= '0;
      start_q <= 1'b0;
      rr_q <= '0;
    end else begin
      state_q <= state_d;
      sdata_q <= sdata_d;
      start_q <= start_d;
      rr_q <= rr_d;
    end
  end
  assign bus.sdata = sdata_q;
  assign bus.tx_start = start_q;
  assign idle = empty & (state_q == S_IDLE);
`ifdef UART_TX_ARB_STATS_EN
  logic [NREQ-1:0][31:0] bytes_q, bytes_d;
  logic [31:0] fullc_q, fullc_d;
  always_comb begin
    for (int k = 0; k < NREQ; k++) bytes_d[k] = bytes_q[k] + 32'(push && gidx == PW'(k));
    fullc_d = fullc_q + 32'(full && |bus.req_valid);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bytes_q <= '0;
      fullc_q <= '0;
    end else begin
      bytes_q <= bytes_d;
      fullc_q <= fullc_d;
    end
  end
  assign stat_bytes = bytes_q;
  assign stat_full_cycles = fullc_q;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, FIFO, sequencer and reset behaviour
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [4:0] fifo_count;
  logic idle;
  logic hold_busy = 1'b0;
  int busy_len = 2;
  int busy_cnt = 0;
  int starts = 0;
  int total = 0;
  int bad = 0;
  int base;
  int s0;
  logic [7:0] log_q[$];
  logic [7:0] acc[$];
`ifdef UART_TX_ARB_STATS_EN
  logic [63:0] stat_bytes;
  logic [31:0] stat_full_cycles;
`endif
  uart_tx_arbiter_if #(.NREQ(2)) bus();
  uart_tx_arbiter #(.NREQ(2), .DEPTH(16)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .fifo_count(fifo_count), .idle(idle)
`ifdef UART_TX_ARB_STATS_EN
    , .stat_bytes(stat_bytes), .stat_full_cycles(stat_full_cycles)
`endif
  );
  always #5 clk = ~clk;
  assign bus.tx_busy = hold_busy | (busy_cnt != 0);
  // Transmitter model: goes busy for busy_len cycles after each start pulse.
  always @(posedge clk) begin
    if (bus.tx_start) begin
      log_q.push_back(bus.sdata);
      starts++;
      busy_cnt <= busy_len;
    end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask
  task automatic send(input int r, input logic [7:0] b);
    int n = 0;
    logic ok = 1'b0;
    bus.req_valid[r] = 1'b1;
    bus.req_data[r*8 +: 8] = b;
    while (!ok && n < 200) begin
      #1 ok = bus.req_ready[r];
      @(negedge clk);
      n++;
    end
    if (!ok) chk("send_timeout", 64'(n), 64'(0));
    bus.req_valid[r] = 1'b0;
  endtask
  task automatic wait_log(input int n);
    int c = 0;
    while (log_q.size() < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("log_wait", 64'(log_q.size() >= n), 64'(1));
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    @(negedge clk);
    do_reset();
    chk("rst_count", 64'(fifo_count), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));
    chk("rst_start", 64'(bus.tx_start), 64'(0));
    chk("rst_sdata", 64'(bus.sdata), 64'(0));
    busy_len = 10;
    bus.req_valid = 2'b01;
    bus.req_data[7:0] = 8'hA5;
    #1 chk("single_ready", 64'(bus.req_ready), 64'(2'b01));
    @(negedge clk);
    bus.req_valid = '0;
    chk("single_cnt1", 64'(fifo_count), 64'(1));
    chk("single_nostart", 64'(bus.tx_start), 64'(0));
    chk("single_busyidle", 64'(idle), 64'(0));
    @(negedge clk);
    chk("single_start", 64'(bus.tx_start), 64'(1));
    chk("single_sdata", 64'(bus.sdata), 64'(8'hA5));
    chk("single_cnt0", 64'(fifo_count), 64'(0));
    s0 = starts;
    repeat (16) @(negedge clk);
    chk("single_onepulse", 64'(starts), 64'(s0 + 1));
    chk("single_idle", 64'(idle), 64'(1));
    chk("single_sdata_hold", 64'(bus.sdata), 64'(8'hA5));
    do_reset();
    busy_len = 2;
    base = log_q.size();
    bus.req_data = 16'h2211;
    bus.req_valid = 2'b11;
    for (int n = 0; n < 100 && acc.size() < 8; n++) begin
      #1 chk("fair_onehot", 64'($countones(bus.req_ready) <= 1), 64'(1));
      if (bus.req_ready[0]) acc.push_back(8'h11);
      if (bus.req_ready[1]) acc.push_back(8'h22);
      @(negedge clk);
    end
    bus.req_valid = '0;
    chk("fair_accepts", 64'(acc.size()), 64'(8));
    for (int i = 0; i < 8; i++) chk("fair_order", 64'(acc[i]), (i % 2) ? 64'h22 : 64'h11);
    wait_log(base + 8);
    for (int i = 0; i < 8; i++) chk("fair_sdata", 64'(log_q[base+i]), (i % 2) ? 64'h22 : 64'h11);
    repeat (10) @(negedge clk);
    do_reset();
    hold_busy = 1'b1;
    base = log_q.size();
    for (int i = 0; i < 16; i++) send(0, 8'(8'h30 + i));
    chk("full_cnt16", 64'(fifo_count), 64'(16));
    bus.req_valid[0] = 1'b1;
    bus.req_data[7:0] = 8'h40;
    #1 chk("full_noready", 64'(bus.req_ready), 64'(0));
    repeat (3) @(negedge clk);
    chk("full_hold16", 64'(fifo_count), 64'(16));
    #1 chk("full_noready2", 64'(bus.req_ready), 64'(0));
    busy_len = 3;
    hold_busy = 1'b0;
    @(negedge clk);
    chk("full_pop_cnt", 64'(fifo_count), 64'(15));
    chk("full_pop_start", 64'(bus.tx_start), 64'(1));
    chk("full_pop_sdata", 64'(bus.sdata), 64'(8'h30));
    #1 chk("full_reready", 64'(bus.req_ready), 64'(2'b01));
    @(negedge clk);
    chk("full_17th", 64'(fifo_count), 64'(16));
    bus.req_valid = '0;
    wait_log(base + 17);
    for (int i = 0; i < 17; i++) chk("full_seq", 64'(log_q[base+i]), 64'(8'h30 + i));
    repeat (10) @(negedge clk);
    do_reset();
    hold_busy = 1'b1;
    busy_len = 2;
    base = log_q.size();
    send(0, 8'h51);
    chk("pp_cnt1", 64'(fifo_count), 64'(1));
    hold_busy = 1'b0;
    bus.req_valid[1] = 1'b1;
    bus.req_data[15:8] = 8'h52;
    @(negedge clk);
    bus.req_valid = '0;
    chk("pp_cnt_same", 64'(fifo_count), 64'(1));
    chk("pp_start", 64'(bus.tx_start), 64'(1));
    chk("pp_sdata", 64'(bus.sdata), 64'(8'h51));
    wait_log(base + 2);
    chk("pp_first", 64'(log_q[base]), 64'(8'h51));
    chk("pp_second", 64'(log_q[base+1]), 64'(8'h52));
    repeat (10) @(negedge clk);
    do_reset();
    busy_len = 1;
    base = log_q.size();
    for (int i = 0; i < 40; i++) send(i % 2, 8'(i));
    wait_log(base + 40);
    for (int i = 0; i < 40; i++) chk("wrap_seq", 64'(log_q[base+i]), 64'(i));
    repeat (10) @(negedge clk);
    chk("wrap_count", 64'(log_q.size()), 64'(base + 40));
    chk("wrap_idle", 64'(idle), 64'(1));
    do_reset();
    busy_len = 20;
    base = log_q.size();
    for (int i = 0; i < 6; i++) send(0, 8'(8'h60 + i));
    repeat (2) @(negedge clk);
    chk("mr_cnt5", 64'(fifo_count), 64'(5));
    chk("mr_busy", 64'(bus.tx_busy), 64'(1));
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("mr_cnt0", 64'(fifo_count), 64'(0));
    chk("mr_start0", 64'(bus.tx_start), 64'(0));
    chk("mr_idle", 64'(idle), 64'(1));
    s0 = starts;
    repeat (40) @(negedge clk);
    chk("mr_nostart", 64'(starts), 64'(s0));
    send(1, 8'h77);
    wait_log(base + 2);
    chk("mr_first", 64'(log_q[base]), 64'(8'h60));
    chk("mr_new", 64'(log_q[base+1]), 64'(8'h77));
    repeat (30) @(negedge clk);
`ifdef UART_TX_ARB_STATS_EN
    do_reset();
    chk("st_rst", 64'(stat_bytes), 64'(0));
    hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) send(0, 8'(i));
    for (int i = 0; i < 2; i++) send(1, 8'(i));
    chk("st_bytes", stat_bytes, {32'd2, 32'd3});
    for (int i = 0; i < 11; i++) send(0, 8'(i));
    chk("st_full", 64'(fifo_count), 64'(16));
    bus.req_valid[0] = 1'b1;
    repeat (4) @(negedge clk);
    bus.req_valid = '0;
    chk("st_full_cycles", 64'(stat_full_cycles), 64'(4));
    chk("st_bytes_r0", 64'(stat_bytes[31:0]), 64'(14));
    hold_busy = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
